// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: data-memory stalls, branch flushes and load-use
// interlocks for a five-stage pipeline, with a stall counter and a sticky memory-timeout flag.
module pipe_hazard_ctrl (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic        E_MemtoReg,
    input  logic [4:0]  E_WriteReg,
    input  logic        E_BranchTaken,
    input  logic        M_MemRead,
    input  logic        M_MemWrite,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        F_en,
    output logic        D_en,
    output logic        E_en,
    output logic        M_en,
    output logic        D_flush,
    output logic        E_flush,
    output logic        W_bubble,
    output logic [15:0] stall_cnt,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        mem_err_q, mem_err_d;

    logic mem_access_s, load_use_s;
    logic mem_req_s, f_en_s, d_en_s, e_en_s, m_en_s, d_flush_s, e_flush_s, w_bubble_s;

    assign mem_access_s = M_MemRead | M_MemWrite;
    assign load_use_s   = E_MemtoReg && (E_WriteReg != 5'd0) &&
                          ((E_WriteReg == D_rs) || (E_WriteReg == D_rt));

    // Next-state, wait counter and raw control outputs; priority is memory stall > branch > load-use.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_req_s  = 1'b0;
        f_en_s     = 1'b1;
        d_en_s     = 1'b1;
        e_en_s     = 1'b1;
        m_en_s     = 1'b1;
        d_flush_s  = 1'b0;
        e_flush_s  = 1'b0;
        w_bubble_s = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_access_s && !mem_ready) begin
                    mem_req_s  = 1'b1;
                    f_en_s     = 1'b0;
                    d_en_s     = 1'b0;
                    e_en_s     = 1'b0;
                    m_en_s     = 1'b0;
                    w_bubble_s = 1'b1;
                    wait_cnt_d = 8'd0;
                    state_d    = MEM_WAIT;
                end else begin
                    mem_req_s = mem_access_s;
                    if (E_BranchTaken) begin
                        d_flush_s = 1'b1;
                        e_flush_s = 1'b1;
                    end else if (load_use_s) begin
                        f_en_s    = 1'b0;
                        d_en_s    = 1'b0;
                        e_flush_s = 1'b1;
                    end else begin
                        e_flush_s = 1'b0;
                    end
                end
            end
            MEM_WAIT: begin
                mem_req_s = 1'b1;
                if (mem_ready) begin
                    state_d = RUN;
                end else begin
                    f_en_s     = 1'b0;
                    d_en_s     = 1'b0;
                    e_en_s     = 1'b0;
                    m_en_s     = 1'b0;
                    w_bubble_s = 1'b1;
                    // The 255th unanswered wait cycle is the timeout.
                    if (wait_cnt_q == 8'd254) begin
                        state_d = ERR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
            end
            ERR: begin
                f_en_s     = 1'b0;
                d_en_s     = 1'b0;
                e_en_s     = 1'b0;
                m_en_s     = 1'b0;
                w_bubble_s = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Stall counter and sticky error flag next values.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q != ERR) && !f_en_s && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        mem_err_d = mem_err_q | (state_d == ERR);
    end

    // State and counter registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= 8'd0;
            stall_cnt_q <= 16'd0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    // Reset forces a free-running pipeline regardless of the live inputs.
    always_comb begin
        if (!Reset) begin
            mem_req  = 1'b0;
            F_en     = 1'b1;
            D_en     = 1'b1;
            E_en     = 1'b1;
            M_en     = 1'b1;
            D_flush  = 1'b0;
            E_flush  = 1'b0;
            W_bubble = 1'b0;
        end else begin
            mem_req  = mem_req_s;
            F_en     = f_en_s;
            D_en     = d_en_s;
            E_en     = e_en_s;
            M_en     = m_en_s;
            D_flush  = d_flush_s;
            E_flush  = e_flush_s;
            W_bubble = w_bubble_s;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign mem_err   = mem_err_q;

endmodule
